// File: rtl/lut_factorial_pkg.sv
// Shared types and widths for the sequential factorial block.
package lut_factorial_pkg;

    localparam int unsigned MAX_N = 20;
    localparam int unsigned N_W   = 32;
    localparam int unsigned F_W   = 64;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lut_mult_64x5.sv
// Combinational 64 x 5 shift-add multiplier; keeps the low 64 product bits.
module lut_mult_64x5
    import lut_factorial_pkg::*;
(
    input  logic [F_W-1:0]   a,
    input  logic [CNT_W-1:0] b,
    output logic [F_W-1:0]   product_c
);

    // One shifted copy of a per set multiplier bit.
    always_comb begin
        product_c = '0;
        for (int i = 0; i < int'(CNT_W); i++) begin
            if (b[i]) begin
                product_c = product_c + (a << i);
            end
        end
    end

endmodule

// File: rtl/seq_factorial.sv
// Iterative n! engine with a four-phase start/output_ready handshake.
module seq_factorial #(
    parameter int unsigned MAX_N = lut_factorial_pkg::MAX_N
) (
    input  logic        clk_32b,
    input  logic        resetn_32b,
    input  logic [31:0] source_number_32b,
    input  logic        start,
    output logic [63:0] factorial,
    output logic        output_ready,
    output logic        overflow,
    output logic        busy
);

    import lut_factorial_pkg::*;

    state_t           state, state_nxt;
    logic [F_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [F_W-1:0]   fact_nxt;
    logic             ovf_nxt;
    logic [F_W-1:0]   prod_c;

    lut_mult_64x5 u_mult (
        .a         (acc),
        .b         (cnt),
        .product_c (prod_c)
    );

    always_ff @(posedge clk_32b or negedge resetn_32b) begin
        if (!resetn_32b) begin
            state        <= IDLE;
            acc          <= F_W'(1);
            cnt          <= '0;
            factorial    <= '0;
            overflow     <= 1'b0;
            output_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            cnt          <= cnt_nxt;
            factorial    <= fact_nxt;
            overflow     <= ovf_nxt;
            output_ready <= (state_nxt == DONE);
            busy         <= (state_nxt == CALC);
        end
    end

    // Operand is sampled only in IDLE, so later input changes are ignored.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        fact_nxt  = factorial;
        ovf_nxt   = overflow;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (source_number_32b > N_W'(MAX_N)) begin
                        state_nxt = DONE;
                        fact_nxt  = '0;
                        ovf_nxt   = 1'b1;
                    end else begin
                        state_nxt = CALC;
                        acc_nxt   = F_W'(1);
                        cnt_nxt   = source_number_32b[CNT_W-1:0];
                    end
                end
            end
            CALC: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                    fact_nxt  = acc;
                    ovf_nxt   = 1'b0;
                end else begin
                    acc_nxt = prod_c;
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_factorial.sv
// Directed self-checking bench for seq_factorial.
`timescale 1ns/1ps
module tb_seq_factorial;

    logic        clk_32b = 1'b0;
    logic        resetn_32b;
    logic [31:0] source_number_32b;
    logic        start;
    logic [63:0] factorial;
    logic        output_ready;
    logic        overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    seq_factorial dut (
        .clk_32b           (clk_32b),
        .resetn_32b        (resetn_32b),
        .source_number_32b (source_number_32b),
        .start             (start),
        .factorial         (factorial),
        .output_ready      (output_ready),
        .overflow          (overflow),
        .busy              (busy)
    );

    always #5 clk_32b = ~clk_32b;

    // Drive start with operand n; returns just after the capturing edge.
    task automatic do_capture(input logic [31:0] n);
        @(negedge clk_32b);
        source_number_32b = n;
        start = 1'b1;
        @(posedge clk_32b);
        #1;
    endtask

    // Edges after the capturing edge until output_ready is seen (bounded).
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!output_ready && cycles < 100) begin
            @(posedge clk_32b);
            #1;
            cycles++;
        end
    endtask

    task automatic end_op(input string name);
        @(negedge clk_32b);
        start = 1'b0;
        @(posedge clk_32b);
        #1;
        checks++;
        if (output_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_drop: got %b want 0", name, output_ready);
        end
    endtask

    task automatic test_reset;
        resetn_32b = 1'b0;
        start = 1'b0;
        source_number_32b = '0;
        #12;
        checks++;
        if ({factorial, output_ready, overflow, busy} !== 67'd0) begin
            failures++;
            $display("FAIL reset_state: got f=%h r=%b o=%b b=%b want all 0",
                     factorial, output_ready, overflow, busy);
        end
        @(negedge clk_32b);
        resetn_32b = 1'b1;
    endtask

    task automatic test_n12_hold;
        int cyc;
        do_capture(32'd12);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL n12_busy: got %b want 1", busy);
        end
        wait_ready(cyc);
        checks++;
        if (cyc != 12) begin
            failures++;
            $display("FAIL n12_latency: got %0d want 12", cyc);
        end
        checks++;
        if (factorial !== 64'h000000001C8CFC00 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL n12_value: got %h o=%b want 000000001c8cfc00 o=0", factorial, overflow);
        end
        // keep start high for the remainder of a 35-cycle hold
        repeat (22) @(posedge clk_32b);
        #1;
        checks++;
        if (output_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL n12_hold: got r=%b b=%b want r=1 b=0", output_ready, busy);
        end
        end_op("n12");
        checks++;
        if (factorial !== 64'h000000001C8CFC00) begin
            failures++;
            $display("FAIL n12_retain_idle: got %h want 000000001c8cfc00", factorial);
        end
    endtask

    task automatic test_input_change;
        int cyc;
        do_capture(32'd13);
        repeat (3) @(posedge clk_32b);
        source_number_32b = 32'd5;
        #1;
        wait_ready(cyc);
        cyc = cyc + 3;
        checks++;
        if (cyc != 13 || factorial !== 64'h000000017328CC00) begin
            failures++;
            $display("FAIL n13_change: got lat=%0d f=%h want lat=13 f=000000017328cc00", cyc, factorial);
        end
        end_op("n13");
    endtask

    task automatic test_small;
        int cyc;
        for (int n = 0; n < 2; n++) begin
            do_capture(32'(n));
            wait_ready(cyc);
            checks++;
            if (cyc != 1 || factorial !== 64'd1) begin
                failures++;
                $display("FAIL n%0d_small: got lat=%0d f=%h want lat=1 f=1", n, cyc, factorial);
            end
            end_op("small");
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit seen;
        do_capture(32'd12);
        repeat (6) @(posedge clk_32b);
        #2;
        resetn_32b = 1'b0;
        #1;
        checks++;
        if ({factorial, output_ready, overflow, busy} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid_zero: got f=%h r=%b o=%b b=%b want all 0",
                     factorial, output_ready, overflow, busy);
        end
        @(negedge clk_32b);
        start = 1'b0;
        resetn_32b = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_32b);
            #1;
            if (output_ready || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_idle: got activity=1 want 0");
        end
        do_capture(32'd3);
        wait_ready(cyc);
        checks++;
        if (cyc != 3 || factorial !== 64'd6) begin
            failures++;
            $display("FAIL reset_restart: got lat=%0d f=%h want lat=3 f=6", cyc, factorial);
        end
        end_op("restart");
    endtask

    task automatic test_boundary;
        int cyc;
        do_capture(32'd20);
        wait_ready(cyc);
        checks++;
        if (cyc != 20 || factorial !== 64'h21C3677C82B40000 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL n20: got lat=%0d f=%h o=%b want lat=20 f=21c3677c82b40000 o=0",
                     cyc, factorial, overflow);
        end
        end_op("n20");
        // overflow result is available right after the capturing edge
        do_capture(32'd21);
        checks++;
        if (output_ready !== 1'b1 || overflow !== 1'b1 || factorial !== 64'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL n21: got r=%b o=%b f=%h b=%b want r=1 o=1 f=0 b=0",
                     output_ready, overflow, factorial, busy);
        end
        end_op("n21");
    endtask

    task automatic test_pulse;
        int cyc;
        do_capture(32'd4);
        @(negedge clk_32b);
        start = 1'b0;
        wait_ready(cyc);
        checks++;
        if (cyc != 4 || factorial !== 64'd24 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL pulse_n4: got lat=%0d f=%h o=%b want lat=4 f=24 o=0", cyc, factorial, overflow);
        end
        @(posedge clk_32b);
        #1;
        checks++;
        if (output_ready !== 1'b0) begin
            failures++;
            $display("FAIL pulse_one_cycle: got %b want 0", output_ready);
        end
    endtask

    initial begin
        test_reset();
        test_n12_hold();
        test_input_change();
        test_small();
        test_reset_mid();
        test_boundary();
        test_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
